// File: rtl/quidditch_pkg.sv
// Shared field geometry, FSM state encoding and winner codes for the quidditch referee logic.
package quidditch_pkg;

  localparam int FIELD_W = 640;
  localparam int FIELD_H = 480;

  localparam logic [9:0] GOAL_ROW_A_Y = 10'd100;
  localparam logic [9:0] GOAL_ROW_B_Y = 10'd450;
  localparam logic [9:0] GOAL_COL_X [3] = '{10'd300, 10'd400, 10'd500};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_TEAM1 = 2'd1;
  localparam logic [1:0] WIN_TEAM2 = 2'd2;

endpackage

// File: rtl/goal_ring_detector.sv
// Stage 1: registered "ball centre inside any of the three rings of one goal row".
module goal_ring_detector
  import quidditch_pkg::*;
#(
  parameter logic [9:0] ROW_Y     = GOAL_ROW_A_Y,
  parameter int         RADIUS_SQ = 484
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       hit
);

  logic signed [10:0] dy;
  logic        [10:0] ady;
  logic        [20:0] sq_y;
  logic        [2:0]  ring_hit;

  // Full-width magnitudes so a ball far from the goal can never alias into range.
  assign dy   = $signed({1'b0, ball_y}) - $signed({1'b0, ROW_Y});
  assign ady  = dy[10] ? (~dy + 11'd1) : dy;
  assign sq_y = {10'd0, ady} * {10'd0, ady};

  for (genvar i = 0; i < 3; i++) begin : g_ring
    logic signed [10:0] dx;
    logic        [10:0] adx;
    logic        [20:0] sq_x;
    logic        [21:0] d2;

    assign dx          = $signed({1'b0, ball_x}) - $signed({1'b0, GOAL_COL_X[i]});
    assign adx         = dx[10] ? (~dx + 11'd1) : dx;
    assign sq_x        = {10'd0, adx} * {10'd0, adx};
    assign d2          = {1'b0, sq_x} + {1'b0, sq_y};
    assign ring_hit[i] = (d2 < 22'(RADIUS_SQ));
  end

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= |ring_hit;
  end

endmodule

// File: rtl/score_keeper.sv
// Referee: detects goals from the ball position, keeps both scores and runs the game flow FSM.
module score_keeper
  import quidditch_pkg::*;
#(
  parameter int BALL_RADIUS = 8,
  parameter int GOAL_RADIUS = 30,
  parameter int GOAL_POINTS = 10,
  parameter int WIN_SCORE   = 50,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       game_on,
  output logic       game_over,
  output logic       goal_pulse,
  output logic [7:0] score_team1,
  output logic [7:0] score_team2,
  output logic [1:0] winner,
  output state_t     dbg_state
);

  localparam int RADIUS_SQ = (GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS);
  localparam int CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic             hit_a, hit_b;
  logic             hit_a_d, hit_b_d;
  logic             edge_a_q, edge_b_q;
  logic             start_q;
  logic             start_rise;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       new_s1, new_s2;

  function automatic logic [7:0] sat_add(input logic [7:0] s);
    logic [8:0] t;
    t = {1'b0, s} + 9'(GOAL_POINTS);
    return t[8] ? 8'hFF : t[7:0];
  endfunction

  goal_ring_detector #(.ROW_Y(GOAL_ROW_A_Y), .RADIUS_SQ(RADIUS_SQ)) u_row_a (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .hit(hit_a)
  );

  goal_ring_detector #(.ROW_Y(GOAL_ROW_B_Y), .RADIUS_SQ(RADIUS_SQ)) u_row_b (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .hit(hit_b)
  );

  assign start_rise = start & ~start_q;
  assign new_s1     = sat_add(score_team1);
  assign new_s2     = sat_add(score_team2);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      game_on     <= 1'b0;
      game_over   <= 1'b0;
      goal_pulse  <= 1'b0;
      score_team1 <= 8'd0;
      score_team2 <= 8'd0;
      winner      <= WIN_NONE;
      start_q     <= 1'b1;
      hit_a_d     <= 1'b0;
      hit_b_d     <= 1'b0;
      edge_a_q    <= 1'b0;
      edge_b_q    <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      start_q    <= start;
      hit_a_d    <= hit_a;
      hit_b_d    <= hit_b;
      // Registered entry edges: a goal lands two edges after the ball is sampled.
      edge_a_q   <= hit_a & ~hit_a_d;
      edge_b_q   <= hit_b & ~hit_b_d;
      goal_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state   <= ST_PLAY;
            game_on <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (edge_a_q || edge_b_q) begin
            goal_pulse <= 1'b1;
            hold_cnt   <= '0;
            state      <= ST_HOLD;
            if (edge_a_q) begin
              score_team1 <= new_s1;
              if (int'(new_s1) >= WIN_SCORE) begin
                state     <= ST_OVER;
                game_on   <= 1'b0;
                game_over <= 1'b1;
                winner    <= WIN_TEAM1;
              end
            end else begin
              score_team2 <= new_s2;
              if (int'(new_s2) >= WIN_SCORE) begin
                state     <= ST_OVER;
                game_on   <= 1'b0;
                game_over <= 1'b1;
                winner    <= WIN_TEAM2;
              end
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
          else if (!hit_a && !hit_b) state <= ST_PLAY;
        end
        ST_OVER: begin
          if (start_rise) begin
            score_team1 <= 8'd0;
            score_team2 <= 8'd0;
            winner      <= WIN_NONE;
            game_over   <= 1'b0;
            game_on     <= 1'b1;
            state       <= ST_PLAY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
